instr_fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the control unit: holds program memory, the PC and the fetch FSM.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program memory, PC and RUN/HALT FSM feeding one registered word per cycle to the control unit.
// JMP and HLT resolve here, so a taken jump costs no bubble and a stall costs exactly the stalled cycles.
module instr_fetch_unit #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter logic [DATA_W-1:0] BUBBLE = 10'b1111000000,
  parameter logic [3:0] JMP_OP = 4'b1001,
  parameter logic [3:0] HLT_OP = 4'b1101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instruction,
  output logic [7:0]        pc,
  output logic              fetch_valid,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt, seq_pc, next_pc;
  logic [DATA_W-1:0]   instr_nxt;
  logic                valid_nxt, halted_nxt, count_en;
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign opcode  = instruction[DATA_W-1 -: 4];
  assign seq_pc  = pc_q + 1'b1;
  assign next_pc = (opcode == JMP_OP) ? instruction[ADDR_W-1:0] : seq_pc;
  assign pc      = {{(8-ADDR_W){1'b0}}, pc_q};

  // Program is loaded only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_q;
    instr_nxt  = instruction;
    valid_nxt  = fetch_valid;
    halted_nxt = halted;
    count_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          valid_nxt = 1'b0;
          instr_nxt = BUBBLE;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt  = RUN;
          halted_nxt = 1'b0;
          valid_nxt  = 1'b0;
          instr_nxt  = BUBBLE;
        end
      end
      RUN: begin
        if (fetch_valid && opcode == HLT_OP) begin
          state_nxt  = HALT;
          pc_nxt     = seq_pc;
          halted_nxt = 1'b1;
          valid_nxt  = 1'b0;
          instr_nxt  = BUBBLE;
        end else if (fetch_valid && !stall) begin
          pc_nxt    = next_pc;
          instr_nxt = mem[next_pc];
          count_en  = 1'b1;
        end else if (fetch_valid) begin
          // Presented word is consumed; pc moves on to the next fetch address.
          pc_nxt    = next_pc;
          valid_nxt = 1'b0;
          instr_nxt = BUBBLE;
        end else if (!stall) begin
          instr_nxt = mem[pc_q];
          valid_nxt = 1'b1;
          count_en  = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        pc_nxt     = '0;
        valid_nxt  = 1'b0;
        halted_nxt = 1'b0;
        instr_nxt  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= '0;
      instruction <= BUBBLE;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      instruction <= instr_nxt;
      fetch_valid <= valid_nxt;
      halted      <= halted_nxt;
      if (count_en && instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: run/halt program, stall, resume, mid-run reset and address wrap.
module tb_instr_fetch_unit;
  logic       clk = 1'b0;
  logic       reset, start, stall, prog_we;
  logic [5:0] prog_addr;
  logic [9:0] prog_data;
  logic [9:0] instruction;
  logic [7:0] pc;
  logic       fetch_valid, halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .pc(pc), .fetch_valid(fetch_valid),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [9:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic exp_word(input string tag, input int p, input logic [9:0] w);
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".instr"}, 32'(instruction), 32'(w));
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd1);
  endtask

  task automatic exp_bubble(input string tag, input int p, input logic h);
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".instr"}, 32'(instruction), 32'h3C0);
    chk({tag, ".valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'(h));
  endtask

  task automatic exp_reset(input string tag);
    exp_bubble(tag, 0, 1'b0);
    chk({tag, ".count"}, 32'(instr_count), 32'd0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_program(input string tag);
    pulse_start();
    exp_bubble({tag, ".first"}, 0, 1'b0);
    tick(); exp_word({tag, ".w0"}, 0, 10'h00A);
    tick(); exp_word({tag, ".w1"}, 1, 10'h0C9);
    tick(); exp_word({tag, ".w2"}, 2, 10'h245);
    tick(); exp_word({tag, ".w5"}, 5, 10'h340);
    tick(); exp_bubble({tag, ".halt"}, 6, 1'b1);
    chk({tag, ".count"}, 32'(instr_count), 32'd4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    tick(); tick();
    reset = 1'b0;
    exp_reset("rst");
    repeat (10) tick();
    exp_reset("idle_hold");

    load(6'd0, 10'h00A);
    load(6'd1, 10'h0C9);
    load(6'd2, 10'h245);
    load(6'd5, 10'h340);
    load(6'd6, 10'h0AB);
    load(6'd7, 10'h340);
    exp_reset("after_load");

    run_program("run");

    // Resume from HALT, with a start pulse during RUN that must be ignored.
    pulse_start();
    exp_bubble("resume.bubble", 6, 1'b0);
    start = 1'b1;
    tick(); exp_word("resume.w6", 6, 10'h0AB);
    start = 1'b0;
    tick(); exp_word("resume.w7", 7, 10'h340);
    tick(); exp_bubble("resume.halt", 8, 1'b1);
    chk("resume.count", 32'(instr_count), 32'd6);

    // Stall while pc=1 is presented.
    do_reset();
    exp_reset("stall.rst");
    pulse_start();
    tick(); exp_word("stall.w0", 0, 10'h00A);
    tick(); exp_word("stall.w1", 1, 10'h0C9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_bubble($sformatf("stall.b%0d", i), 2, 1'b0);
    end
    stall = 1'b0;
    tick(); exp_word("stall.w2", 2, 10'h245);
    tick(); exp_word("stall.w5", 5, 10'h340);
    chk("stall.count", 32'(instr_count), 32'd4);

    // Mid-run reset at pc=2, then replay.
    do_reset();
    pulse_start();
    tick(); tick(); tick();
    exp_word("mid.w2", 2, 10'h245);
    do_reset();
    exp_reset("mid.rst");
    run_program("replay");

    // Address wrap 0 -> 63 -> 0, with writes attempted during RUN.
    do_reset();
    load(6'd0, 10'h27F);
    load(6'd63, 10'h00A);
    pulse_start();
    exp_bubble("wrap.first", 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_word($sformatf("wrap.a%0d", i), 0, 10'h27F);
      prog_we = 1'b1; prog_addr = 6'd63; prog_data = 10'h111;
      tick(); exp_word($sformatf("wrap.b%0d", i), 63, 10'h00A);
      prog_we = 1'b0;
    end
    chk("wrap.count", 32'(instr_count), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
